// File: rtl/uart_rx_subsystem.sv
// uart_rx_subsystem
//   UART receiver with 16x oversampling, optional even/odd parity, framing
//   error and break detection, feeding a first-word-fall-through FIFO of
//   2**FIFO_EXP entries. Each entry is {brk, ferr, perr, data}.
//
// Ports
//   clk_50MHz    system clock, rising edge
//   reset        asynchronous reset, active low
//   rx           serial line, idle high (asynchronous to clk_50MHz)
//   baud_div     oversample tick period minus one, in clocks
//   parity_mode  00/11 none, 01 even, 10 odd (latched at start of frame)
//   read_uart    pop head entry (ignored while rx_empty)
//   clr_overrun  clear sticky overrun flag
//   read_data    head entry data, LSB = first received bit
//   read_perr / read_ferr / read_brk   head entry status bits
//   rx_empty, rx_full                  FIFO status
//   overrun      sticky: a frame was dropped because the FIFO was full
module uart_rx_subsystem #(
    parameter int DATA_BITS = 8,
    parameter int BR_BITS   = 9,
    parameter int FIFO_EXP  = 4
) (
    input  logic                 clk_50MHz,
    input  logic                 reset,
    input  logic                 rx,
    input  logic [BR_BITS-1:0]   baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 read_uart,
    input  logic                 clr_overrun,
    output logic [DATA_BITS-1:0] read_data,
    output logic                 read_perr,
    output logic                 read_ferr,
    output logic                 read_brk,
    output logic                 rx_empty,
    output logic                 rx_full,
    output logic                 overrun
);

    localparam int DEPTH = 1 << FIFO_EXP;
    localparam int NB    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [NB-1:0] LAST_BIT = NB'(DATA_BITS - 1);

    typedef struct packed {
        logic                 brk;
        logic                 ferr;
        logic                 perr;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // ------------------------------------------------------------------
    // Synchronizer and start-edge qualification
    // ------------------------------------------------------------------
    logic [1:0] sync_ff;
    logic [1:0] sync_vld;   // shifts in 1s after reset until sync_ff holds real line data
    logic       rx_s;
    logic       rx_prev;

    assign rx_s = sync_ff[1];

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            sync_ff  <= 2'b11;
            sync_vld <= 2'b00;
            rx_prev  <= 1'b0;
        end else begin
            sync_ff  <= {sync_ff[0], rx};
            sync_vld <= {sync_vld[0], 1'b1};
            // rx_prev stays 0 until the synchronizer is flushed, so a line
            // that is already low when reset releases never looks like a
            // fresh falling edge.
            if (sync_vld[1])
                rx_prev <= rx_s;
        end
    end

    // ------------------------------------------------------------------
    // Oversample tick generator. ">=" lets a shrinking baud_div wrap at once
    // instead of running the counter all the way round.
    // ------------------------------------------------------------------
    logic [BR_BITS-1:0] br_cnt;
    logic               tick;

    assign tick = (br_cnt >= baud_div);

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset)
            br_cnt <= '0;
        else if (tick)
            br_cnt <= '0;
        else
            br_cnt <= br_cnt + 1'b1;
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t               state;
    logic [3:0]           s_cnt;
    logic [NB-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 wr_en;
    entry_t               wr_entry;
    logic                 perr_calc;
    logic                 brk_calc;

    // Even: error when data^parity is odd. Odd: error when it is even.
    assign perr_calc = par_en_q & ((^shreg) ^ par_bit ^ par_odd_q);
    // par_bit is cleared at frame start, so it reads 0 when parity is off.
    assign brk_calc  = ~rx_s & (shreg == '0) & ~par_bit;

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            s_cnt     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            wr_en     <= 1'b0;
            wr_entry  <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state     <= START;
                        s_cnt     <= '0;
                        par_en_q  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                        par_odd_q <= (parity_mode == 2'b10);
                    end
                end
                START: begin
                    if (tick) begin
                        if (s_cnt == 4'd7) begin
                            // Mid start bit: a high line here was a glitch.
                            s_cnt   <= '0;
                            bit_cnt <= '0;
                            par_bit <= 1'b0;
                            state   <= rx_s ? IDLE : DATA;
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s_cnt == 4'd15) begin
                            s_cnt <= '0;
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == LAST_BIT)
                                state <= par_en_q ? PARITY : STOP;
                            else
                                bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        if (s_cnt == 4'd15) begin
                            s_cnt   <= '0;
                            par_bit <= rx_s;
                            state   <= STOP;
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s_cnt == 4'd15) begin
                            s_cnt         <= '0;
                            wr_en         <= 1'b1;
                            wr_entry.brk  <= brk_calc;
                            wr_entry.ferr <= ~rx_s;
                            wr_entry.perr <= perr_calc;
                            wr_entry.data <= shreg;
                            state         <= IDLE;
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FWFT FIFO with an extra pointer MSB to separate full from empty
    // ------------------------------------------------------------------
    entry_t            mem [DEPTH];
    logic [FIFO_EXP:0] wptr;
    logic [FIFO_EXP:0] rptr;
    logic              do_rd;
    logic              do_wr;
    logic              ovr_set;
    entry_t            head;

    assign rx_empty = (wptr == rptr);
    assign rx_full  = (wptr[FIFO_EXP] != rptr[FIFO_EXP]) &&
                      (wptr[FIFO_EXP-1:0] == rptr[FIFO_EXP-1:0]);

    assign do_rd   = read_uart & ~rx_empty;
    // When full, a simultaneous pop frees the head slot that the write
    // pointer aliases, so the write is accepted.
    assign do_wr   = wr_en & (~rx_full | do_rd);
    assign ovr_set = wr_en & rx_full & ~do_rd;

    always_ff @(posedge clk_50MHz) begin
        if (do_wr)
            mem[wptr[FIFO_EXP-1:0]] <= wr_entry;
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            wptr    <= '0;
            rptr    <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_wr)
                wptr <= wptr + 1'b1;
            if (do_rd)
                rptr <= rptr + 1'b1;
            // Set wins over clear in the same clock.
            if (ovr_set)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

    assign head      = mem[rptr[FIFO_EXP-1:0]];
    assign read_data = head.data;
    assign read_perr = head.perr;
    assign read_ferr = head.ferr;
    assign read_brk  = head.brk;

endmodule

// File: tb/tb_uart_rx_subsystem.sv
module tb_uart_rx_subsystem;

    localparam int DB     = 8;
    localparam int BRB    = 9;
    localparam int FE     = 2;
    localparam int BITCLK = 64;   // 16 ticks * (baud_div + 1)

    logic           clk_50MHz = 1'b0;
    logic           reset = 1'b0;
    logic           rx = 1'b1;
    logic [BRB-1:0] baud_div = 9'd3;
    logic [1:0]     parity_mode = 2'b00;
    logic           read_uart = 1'b0;
    logic           clr_overrun = 1'b0;
    logic [DB-1:0]  read_data;
    logic           read_perr, read_ferr, read_brk;
    logic           rx_empty, rx_full, overrun;

    uart_rx_subsystem #(.DATA_BITS(DB), .BR_BITS(BRB), .FIFO_EXP(FE)) dut (
        .clk_50MHz  (clk_50MHz),
        .reset      (reset),
        .rx         (rx),
        .baud_div   (baud_div),
        .parity_mode(parity_mode),
        .read_uart  (read_uart),
        .clr_overrun(clr_overrun),
        .read_data  (read_data),
        .read_perr  (read_perr),
        .read_ferr  (read_ferr),
        .read_brk   (read_brk),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full),
        .overrun    (overrun)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    int checks = 0;
    int errors = 0;
    logic [10:0] sb[$];   // {brk, ferr, perr, data}

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk_50MHz);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        clks(BITCLK);
    endtask

    // Sends one frame; lat = clocks from stop-bit start to rx_empty falling.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pb,
                              input logic stop, input logic store, output int lat);
        logic perr_e, brk_e;
        perr_e = pen ? ((^d) ^ pb ^ (parity_mode == 2'b10)) : 1'b0;
        brk_e  = !stop && (d == 8'h00) && (!pen || !pb);
        if (store)
            sb.push_back({brk_e, !stop, perr_e, d});
        lat = -1;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++)
            drive_bit(d[i]);
        if (pen)
            drive_bit(pb);
        rx = stop;
        for (int i = 0; i < BITCLK; i++) begin
            @(posedge clk_50MHz);
            #1;
            if (lat < 0 && !rx_empty)
                lat = i;
        end
        drive_bit(1'b1);
    endtask

    task automatic pop_chk(input string tag);
        logic [10:0] e;
        chk({tag, "_sb"}, 32'(sb.size() != 0), 1);
        if (sb.size() == 0)
            return;
        e = sb.pop_front();
        @(negedge clk_50MHz);
        chk({tag, "_empty"}, rx_empty, 0);
        chk({tag, "_data"},  read_data, e[7:0]);
        chk({tag, "_perr"},  read_perr, e[8]);
        chk({tag, "_ferr"},  read_ferr, e[9]);
        chk({tag, "_brk"},   read_brk,  e[10]);
        @(posedge clk_50MHz); #1;
        read_uart = 1'b1;
        @(posedge clk_50MHz); #1;
        read_uart = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        // Reset state
        clks(5);
        @(negedge clk_50MHz);
        chk("rst_empty", rx_empty, 1);
        chk("rst_full",  rx_full,  0);
        chk("rst_ovr",   overrun,  0);
        @(posedge clk_50MHz); #1;
        reset = 1'b1;
        clks(5);

        // Basic frame and write latency
        send_frame(8'h55, 0, 0, 1, 1, lat);
        chk("lat_55", 32'(lat >= 31 && lat <= 36), 1);
        pop_chk("f55");

        // Parity: even wrong, even right, odd right
        parity_mode = 2'b01;
        send_frame(8'hA3, 1, 1, 1, 1, lat);
        pop_chk("evn_bad");
        send_frame(8'hA3, 1, 0, 1, 1, lat);
        pop_chk("evn_ok");
        parity_mode = 2'b10;
        send_frame(8'hA3, 1, 1, 1, 1, lat);
        pop_chk("odd_ok");
        parity_mode = 2'b00;

        // Framing error and break
        send_frame(8'h3C, 0, 0, 0, 1, lat);
        pop_chk("ferr");
        send_frame(8'h00, 0, 0, 0, 1, lat);
        pop_chk("brk");

        // False start: 5 ticks low
        rx = 1'b0;
        clks(20);
        rx = 1'b1;
        clks(3 * BITCLK);
        @(negedge clk_50MHz);
        chk("fs_empty", rx_empty, 1);
        send_frame(8'h5A, 0, 0, 1, 1, lat);
        pop_chk("after_fs");

        // Fill to full, then overrun
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 0, 0, 1, k <= 4, lat);
            @(negedge clk_50MHz);
            if (k == 4) begin
                chk("full4",  rx_full, 1);
                chk("ovr4",   overrun, 0);
            end
        end
        chk("full5", rx_full, 1);
        chk("ovr5",  overrun, 1);
        for (int k = 1; k <= 4; k++)
            pop_chk("ovf_pop");
        @(negedge clk_50MHz);
        chk("ovf_empty", rx_empty, 1);
        chk("ovr_held",  overrun,  1);
        @(posedge clk_50MHz); #1;
        clr_overrun = 1'b1;
        @(posedge clk_50MHz); #1;
        clr_overrun = 1'b0;
        @(negedge clk_50MHz);
        chk("ovr_clr", overrun, 0);

        // Reset in the middle of frame 0x77 (during a low data bit)
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rx = 1'b0;
        clks(20);
        reset = 1'b0;
        clks(4);
        reset = 1'b1;
        clks(40);
        rx = 1'b1;
        clks(2 * BITCLK);
        @(negedge clk_50MHz);
        chk("mid_rst_empty", rx_empty, 1);
        send_frame(8'h12, 0, 0, 1, 1, lat);
        pop_chk("f12");
        @(negedge clk_50MHz);
        chk("end_empty", rx_empty, 1);
        chk("end_sb", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
